// File: rtl/memory_mp_pkg.sv
// memory_mp_pkg
//   Shared definitions for the multi-port Wishbone RAM (memory_mp_wb):
//   lane/address-LSB helpers, the address range check and the per-port
//   request record that each port front end hands to the storage core.
//   Request fields are sized for the widest supported word
//   (MP_MAX_DATA_WIDTH). Narrower instances use only the low bits.
package memory_mp_pkg;

    localparam int unsigned MP_ADR_WIDTH      = 32;
    localparam int unsigned MP_MAX_DATA_WIDTH = 128;
    localparam int unsigned MP_MAX_LANES      = MP_MAX_DATA_WIDTH / 8;

    typedef struct packed {
        logic                          valid;  // in-range request, not in reset
        logic                          we;
        logic [MP_ADR_WIDTH-1:0]       idx;    // full word index, untruncated
        logic [MP_MAX_LANES-1:0]       sel;
        logic [MP_MAX_DATA_WIDTH-1:0]  wdat;
    } mp_req_t;

    function automatic int unsigned lane_count(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Every upper address bit takes part, so aliased high addresses are
    // rejected rather than wrapping onto a valid word.
    function automatic logic in_range(input logic [MP_ADR_WIDTH-1:0] adr,
                                      input int unsigned             lsb,
                                      input int unsigned             depth);
        return (adr >> lsb) < depth;
    endfunction

endpackage

// File: rtl/memory_mp_wb_port.sv
// memory_mp_wb_port
//   Front end for one Wishbone (pipelined B4) slave port: decodes and
//   range-checks the byte address, builds the request record for the
//   storage core and registers the ack/err termination.
//   Ports:
//     wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//     wb_cyc_i, wb_stb_i      cycle / strobe
//     wb_we_i                 write enable
//     wb_adr_i [31:0]         byte address
//     wb_dat_i, wb_sel_i      write data, byte-lane selects
//     req                     request record to the storage core
//     wb_ack_o, wb_err_o      registered terminations (1-cycle latency)
module memory_mp_wb_port
    import memory_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    localparam int unsigned NUM_LANES = lane_count(DATA_WIDTH),
    localparam int unsigned ADDR_LSB  = addr_lsb(DATA_WIDTH)
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [NUM_LANES-1:0]    wb_sel_i,
    output mp_req_t                 req,
    output logic                    wb_ack_o,
    output logic                    wb_err_o
);

    logic hit;

    always_comb begin
        hit                        = in_range(wb_adr_i, ADDR_LSB, DEPTH);
        req                        = '0;
        req.valid                  = !wb_rst_i && wb_cyc_i && wb_stb_i && hit;
        req.we                     = wb_we_i;
        req.idx                    = wb_adr_i >> ADDR_LSB;
        req.sel[NUM_LANES-1:0]     = wb_sel_i;
        req.wdat[DATA_WIDTH-1:0]   = wb_dat_i;
    end

    // Dropping cyc clears any termination in flight, so an aborted cycle
    // never sees a late ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !wb_cyc_i || !wb_stb_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            wb_ack_o <= hit;
            wb_err_o <= !hit;
        end
    end

endmodule

// File: rtl/memory_mp_wb.sv
// memory_mp_wb
//   NUM_PORTS-port Wishbone (pipelined B4) on-chip RAM on a single clock.
//   Fixed 1-cycle ack/err/read latency, stall never asserted.
//   Out-of-range requests terminate with err.
//   Same-word writes on one edge are resolved per byte lane, the lowest
//   port index wins. A read colliding with a write returns the old word,
//   unless MEMORY_MP_FORWARD_EN is defined, in which case it returns the
//   word as written at that edge.
//   DEPTH must be at least 2. DATA_WIDTH is a multiple of 8, up to 128.
//   Ports (port p occupies slice p of each bus):
//     wb_clk_i, wb_rst_i               clock, synchronous active-high reset
//     wb_cyc_i, wb_stb_i, wb_we_i      [NUM_PORTS]
//     wb_adr_i                         [NUM_PORTS*32] byte addresses
//     wb_dat_i / wb_dat_o              [NUM_PORTS*DATA_WIDTH]
//     wb_sel_i                         [NUM_PORTS*NUM_LANES]
//     wb_ack_o, wb_err_o, wb_stall_o   [NUM_PORTS]
module memory_mp_wb
    import memory_mp_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 512,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned NUM_LANES  = DATA_WIDTH / 8
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic [NUM_PORTS-1:0]             wb_cyc_i,
    input  logic [NUM_PORTS-1:0]             wb_stb_i,
    input  logic [NUM_PORTS-1:0]             wb_we_i,
    input  logic [NUM_PORTS*32-1:0]          wb_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wb_dat_i,
    input  logic [NUM_PORTS*NUM_LANES-1:0]   wb_sel_i,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  wb_dat_o,
    output logic [NUM_PORTS-1:0]             wb_ack_o,
    output logic [NUM_PORTS-1:0]             wb_err_o,
    output logic [NUM_PORTS-1:0]             wb_stall_o
);

    logic [DATA_WIDTH-1:0] mem     [DEPTH];
    mp_req_t               req     [NUM_PORTS];
    logic [NUM_LANES-1:0]  win     [NUM_PORTS];
    logic [DATA_WIDTH-1:0] rd_word [NUM_PORTS];
    logic [DATA_WIDTH-1:0] dat_q   [NUM_PORTS];

    assign wb_stall_o = '0;

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        logic unused_req_bits;

        memory_mp_wb_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_port (
            .wb_clk_i (wb_clk_i),
            .wb_rst_i (wb_rst_i),
            .wb_cyc_i (wb_cyc_i[gp]),
            .wb_stb_i (wb_stb_i[gp]),
            .wb_we_i  (wb_we_i[gp]),
            .wb_adr_i (wb_adr_i[gp*32 +: 32]),
            .wb_dat_i (wb_dat_i[gp*DATA_WIDTH +: DATA_WIDTH]),
            .wb_sel_i (wb_sel_i[gp*NUM_LANES +: NUM_LANES]),
            .req      (req[gp]),
            .wb_ack_o (wb_ack_o[gp]),
            .wb_err_o (wb_err_o[gp])
        );

        assign wb_dat_o[gp*DATA_WIDTH +: DATA_WIDTH] = dat_q[gp];
        // Record fields are sized for the widest word; upper bits are spare.
        assign unused_req_bits = ^req[gp];
    end

    // A lane write wins unless a lower-indexed port writes the same lane of
    // the same word at this edge. At most one winner per word lane.
    always_comb begin
        win = '{default: '0};
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                win[p][l] = req[p].valid && req[p].we && req[p].sel[l];
                for (int unsigned k = 0; k < p; k++) begin
                    if (req[k].valid && req[k].we && req[k].sel[l] &&
                        req[k].idx == req[p].idx)
                        win[p][l] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (win[p][l])
                    mem[req[p].idx[ADDR_WIDTH-1:0]][l*8 +: 8] <= req[p].wdat[l*8 +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '{default: '0};
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rd_word[p] = mem[req[p].idx[ADDR_WIDTH-1:0]];
`ifdef MEMORY_MP_FORWARD_EN
            // Overlay this edge's winning lane writes to the same word.
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                for (int unsigned l = 0; l < NUM_LANES; l++) begin
                    if (win[k][l] && req[k].idx == req[p].idx)
                        rd_word[p][l*8 +: 8] = req[k].wdat[l*8 +: 8];
                end
            end
`endif
        end
    end

    always_ff @(posedge wb_clk_i) begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (wb_rst_i)
                dat_q[p] <= '0;
            else if (req[p].valid && !req[p].we)
                dat_q[p] <= rd_word[p];
        end
    end

endmodule

// File: tb/tb_memory_mp_wb.sv
// tb_memory_mp_wb
//   Directed self-checking bench for memory_mp_wb: two 32-bit ports,
//   DEPTH=500 so the range boundary sits at byte address 0x7D0.
//   The expected value of a read/write collision depends on whether
//   MEMORY_MP_FORWARD_EN is defined for the build.
module tb_memory_mp_wb;

    localparam int unsigned NP    = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned NL    = 4;
    localparam int unsigned DEPTH = 500;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     cyc, stb, we;
    logic [NP*32-1:0]  adr;
    logic [NP*DW-1:0]  dati;
    logic [NP*NL-1:0]  sel;
    logic [NP*DW-1:0]  dato;
    logic [NP-1:0]     ack, err, stall;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_fwd;

    memory_mp_wb #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (dati),
        .wb_sel_i   (sel),
        .wb_dat_o   (dato),
        .wb_ack_o   (ack),
        .wb_err_o   (err),
        .wb_stall_o (stall)
    );

    always #5 clk = ~clk;

    task automatic idle();
        cyc = '0; stb = '0; we = '0; adr = '0; dati = '0; sel = '0;
    endtask

    task automatic drive(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cyc[p] = 1'b1;
        stb[p] = 1'b1;
        we[p]  = w;
        adr[p*32 +: 32] = a;
        dati[p*DW +: DW] = d;
        sel[p*NL +: NL] = s;
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rd(input int p);
        return dato[p*DW +: DW];
    endfunction

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_ack", {30'd0, ack}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);
        chk("rst_dat0", rd(0), 32'd0);
        chk("rst_dat1", rd(1), 32'd0);
        chk("stall", {30'd0, stall}, 32'd0);
        rst = 1'b0;

        // Write then read from the other port.
        drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        step();
        chk("wr_ack0", {31'd0, ack[0]}, 32'd1);
        chk("wr_err0", {31'd0, err[0]}, 32'd0);
        idle();
        drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
        step();
        chk("rd_ack1", {31'd0, ack[1]}, 32'd1);
        chk("rd_dat1", rd(1), 32'hDEADBEEF);
        chk("idle_ack0", {31'd0, ack[0]}, 32'd0);

        // Same-edge write collision, per-lane lowest port wins.
        idle();
        drive(0, 1'b1, 32'h20, 32'h11111111, 4'h3);
        drive(1, 1'b1, 32'h20, 32'h22222222, 4'hF);
        step();
        chk("col_ack", {30'd0, ack}, 32'd3);
        idle();
        drive(0, 1'b0, 32'h20, 32'h0, 4'hF);
        step();
        chk("col_dat", rd(0), 32'h22221111);

        // Range boundary: word 500 errors, word 499 acks.
        idle();
        drive(1, 1'b0, 32'h7D0, 32'h0, 4'hF);
        step();
        chk("oor_err", {31'd0, err[1]}, 32'd1);
        chk("oor_ack", {31'd0, ack[1]}, 32'd0);
        chk("oor_dat", rd(1), 32'hDEADBEEF);
        idle();
        drive(1, 1'b0, 32'h7CC, 32'h0, 4'hF);
        step();
        chk("last_ack", {31'd0, ack[1]}, 32'd1);
        chk("last_err", {31'd0, err[1]}, 32'd0);

        // High address that would alias word 4 if truncated must not write.
        idle();
        drive(0, 1'b1, 32'h80000010, 32'h12345678, 4'hF);
        step();
        chk("hi_err", {31'd0, err[0]}, 32'd1);
        idle();
        step();
        chk("err_clr", {30'd0, err}, 32'd0);
        drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
        step();
        chk("hi_nowr", rd(0), 32'hDEADBEEF);

        // Read/write collision.
        idle();
        drive(0, 1'b1, 32'h40, 32'h00000000, 4'hF);
        step();
        idle();
        drive(0, 1'b1, 32'h40, 32'hA5A5A5A5, 4'hF);
        drive(1, 1'b0, 32'h40, 32'h0, 4'hF);
        step();
`ifdef MEMORY_MP_FORWARD_EN
        exp_fwd = 32'hA5A5A5A5;
`else
        exp_fwd = 32'h00000000;
`endif
        chk("rw_col", rd(1), exp_fwd);
        chk("rw_ack", {30'd0, ack}, 32'd3);
        idle();
        drive(1, 1'b0, 32'h40, 32'h0, 4'hF);
        step();
        chk("rw_after", rd(1), 32'hA5A5A5A5);

        // Abort: cyc dropped at the edge after the request.
        idle();
        drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
        step();
        idle();
        step();
        chk("abort_ack", {31'd0, ack[1]}, 32'd0);
        step();
        chk("abort_late", {31'd0, ack[1]}, 32'd0);

        // Reset while a write is presented.
        drive(0, 1'b1, 32'h10, 32'h77777777, 4'hF);
        drive(1, 1'b0, 32'h20, 32'h0, 4'hF);
        rst = 1'b1;
        step();
        chk("rstw_ack", {30'd0, ack}, 32'd0);
        chk("rstw_err", {30'd0, err}, 32'd0);
        chk("rstw_dat0", rd(0), 32'd0);
        chk("rstw_dat1", rd(1), 32'd0);
        rst = 1'b0;
        idle();
        drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
        step();
        chk("rstw_keep", rd(0), 32'hDEADBEEF);

        // Back-to-back reads, sel ignored on port 1.
        idle();
        drive(0, 1'b1, 32'h0, 32'hC0C0C0C0, 4'hF);
        drive(1, 1'b1, 32'h4, 32'hC4C4C4C4, 4'hF);
        step();
        idle();
        drive(0, 1'b1, 32'h8, 32'hC8C8C8C8, 4'hF);
        step();
        idle();
        drive(0, 1'b0, 32'h0, 32'h0, 4'hF);
        drive(1, 1'b0, 32'h8, 32'h0, 4'h0);
        step();
        chk("b2b_ack_a", {30'd0, ack}, 32'd3);
        chk("b2b_p0_a", rd(0), 32'hC0C0C0C0);
        chk("b2b_p1_a", rd(1), 32'hC8C8C8C8);
        drive(0, 1'b0, 32'h4, 32'h0, 4'hF);
        drive(1, 1'b0, 32'h4, 32'h0, 4'h0);
        step();
        chk("b2b_ack_b", {30'd0, ack}, 32'd3);
        chk("b2b_p0_b", rd(0), 32'hC4C4C4C4);
        chk("b2b_p1_b", rd(1), 32'hC4C4C4C4);
        drive(0, 1'b0, 32'h8, 32'h0, 4'hF);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        chk("b2b_ack_c", {30'd0, ack}, 32'd3);
        chk("b2b_p0_c", rd(0), 32'hC8C8C8C8);
        chk("b2b_p1_c", rd(1), 32'hC0C0C0C0);
        idle();
        step();
        chk("b2b_end", {30'd0, ack}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
